// File: rtl/srl_pkg.sv
// Shared encodings for the SR latch pulse scheduler: FSM states, grant codes
// and the width of the pulse/recovery down-counter.
package srl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_PULSE   = 2'b01,
      ST_RECOVER = 2'b10
   } state_t;

   typedef enum logic {
      GRANT_CLR = 1'b0,
      GRANT_SET = 1'b1
   } grant_t;

   localparam int TIMER_W = 4;

   // Counter load value for a phase lasting `cycles` clocks (terminal count is 0).
   function automatic logic [TIMER_W-1:0] phase_load(input int cycles);
      return TIMER_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/pulse_timer.sv
// 4-bit down-counter that times PULSE and RECOVER phases; parks at zero
// until the next load.
module pulse_timer
   import srl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_value,
   output logic [TIMER_W-1:0] value,
   output logic               zero
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst)
         value <= '0;
      else if (load)
         value <= load_value;
      else if (value != '0)
         value <= value - 1'b1;
   end

   assign zero = (value == '0);

endmodule

// File: rtl/sr_pulse_scheduler.sv
// Arbitrates set/clear requests onto an SR latch, guaranteeing s and r are never
// high together, fixed-width pulses, and an enforced recovery gap after each.
module sr_pulse_scheduler
   import srl_pkg::*;
#(
   parameter int PULSE_W = 2,
   parameter int RECOV_W = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic set_req,
   input  logic clr_req,
   output logic s,
   output logic r,
   output logic ack_set,
   output logic ack_clr,
   output logic busy,
   output logic q_shadow
);

   localparam logic [TIMER_W-1:0] PULSE_LOAD   = phase_load(PULSE_W);
   localparam logic [TIMER_W-1:0] RECOV_LOAD   = phase_load(RECOV_W);
   localparam logic               ACK_ON_ENTRY = (RECOV_W == 1);

   state_t               state;
   grant_t               last_grant;
   grant_t               cur_grant;
   grant_t               pick;
   logic                 init_pending;
   logic                 init_op;
   logic                 want;
   logic                 redundant;
   logic                 go_pulse;
   logic                 go_recover;
   logic                 timer_load;
   logic [TIMER_W-1:0]   timer_load_value;
   logic [TIMER_W-1:0]   timer_value;
   logic                 timer_zero;

   // NOTE: every signal in this block gets a value on every path, so no latches.
   always_comb begin
      want = set_req | clr_req;
      if (set_req && clr_req)
         pick = (last_grant == GRANT_SET) ? GRANT_CLR : GRANT_SET;
      else if (set_req)
         pick = GRANT_SET;
      else
         pick = GRANT_CLR;
      redundant        = (pick == GRANT_SET) ? q_shadow : !q_shadow;
      go_pulse         = (state == ST_IDLE) && (init_pending || (want && !redundant));
      go_recover       = ((state == ST_IDLE) && !init_pending && want && redundant) ||
                         ((state == ST_PULSE) && timer_zero);
      timer_load       = go_pulse || go_recover;
      timer_load_value = go_pulse ? PULSE_LOAD : RECOV_LOAD;
   end

   pulse_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (timer_load),
      .load_value (timer_load_value),
      .value      (timer_value),
      .zero       (timer_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         s            <= 1'b0;
         r            <= 1'b0;
         ack_set      <= 1'b0;
         ack_clr      <= 1'b0;
         busy         <= 1'b1;
         q_shadow     <= 1'b0;
         last_grant   <= GRANT_CLR;
         cur_grant    <= GRANT_CLR;
         init_pending <= 1'b1;
         init_op      <= 1'b0;
      end else begin
         ack_set <= 1'b0;
         ack_clr <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (init_pending) begin
                  // Power-up clear pulse puts the physical latch in a known state.
                  state        <= ST_PULSE;
                  r            <= 1'b1;
                  q_shadow     <= 1'b0;
                  init_pending <= 1'b0;
                  init_op      <= 1'b1;
                  busy         <= 1'b1;
               end else if (want) begin
                  last_grant <= pick;
                  cur_grant  <= pick;
                  init_op    <= 1'b0;
                  busy       <= 1'b1;
                  if (redundant) begin
                     state   <= ST_RECOVER;
                     ack_set <= ACK_ON_ENTRY && (pick == GRANT_SET);
                     ack_clr <= ACK_ON_ENTRY && (pick == GRANT_CLR);
                  end else begin
                     state    <= ST_PULSE;
                     s        <= (pick == GRANT_SET);
                     r        <= (pick == GRANT_CLR);
                     q_shadow <= (pick == GRANT_SET);
                  end
               end
            end
            ST_PULSE: begin
               if (timer_zero) begin
                  state   <= ST_RECOVER;
                  s       <= 1'b0;
                  r       <= 1'b0;
                  ack_set <= ACK_ON_ENTRY && !init_op && (cur_grant == GRANT_SET);
                  ack_clr <= ACK_ON_ENTRY && !init_op && (cur_grant == GRANT_CLR);
               end
            end
            ST_RECOVER: begin
               if (timer_zero) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (timer_value == TIMER_W'(1)) begin
                  // Ack lands on the last RECOVER cycle, i.e. when the counter is about to hit 0.
                  ack_set <= !init_op && (cur_grant == GRANT_SET);
                  ack_clr <= !init_op && (cur_grant == GRANT_CLR);
               end
            end
            default: begin
               state <= ST_IDLE;
               s     <= 1'b0;
               r     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sr_pulse_scheduler.sv
// Self-checking bench: directed cycle table on a default instance, hand-written
// reset/round-robin sequence, and a random request stream on a 3/2 instance.
module tb_sr_pulse_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic set0 = 1'b0, clr0 = 1'b0, set1 = 1'b0, clr1 = 1'b0;
   logic s0, r0, ack_set0, ack_clr0, busy0, q_shadow0;
   logic s1, r1, ack_set1, ack_clr1, busy1, q_shadow1;
   logic lq0, lq1;
   logic [5:0] o0;
   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   sr_pulse_scheduler u_dut0 (
      .clk(clk), .rst(rst), .set_req(set0), .clr_req(clr0),
      .s(s0), .r(r0), .ack_set(ack_set0), .ack_clr(ack_clr0),
      .busy(busy0), .q_shadow(q_shadow0)
   );

   sr_pulse_scheduler #(.PULSE_W(3), .RECOV_W(2)) u_dut1 (
      .clk(clk), .rst(rst), .set_req(set1), .clr_req(clr1),
      .s(s1), .r(r1), .ack_set(ack_set1), .ack_clr(ack_clr1),
      .busy(busy1), .q_shadow(q_shadow1)
   );

   assign o0 = {s0, r0, ack_set0, ack_clr0, busy0, q_shadow0};

   // Behavioural SR latches driven by each scheduler.
   always @(posedge clk) begin
      if (s0) lq0 <= 1'b1; else if (r0) lq0 <= 1'b0;
      if (s1) lq1 <= 1'b1; else if (r1) lq1 <= 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      assert (!(s0 && r0)) else $error("FAIL excl0: s and r both high");
      assert (!(s1 && r1)) else $error("FAIL excl1: s and r both high");
   end

   // After every ack the physical latch must agree with q_shadow and the request.
   always @(negedge clk) begin
      if (!rst && (ack_set0 || ack_clr0))
         check("latch0_at_ack", 32'({lq0, q_shadow0}), ack_set0 ? 32'h3 : 32'h0);
   end

   typedef struct {
      logic       set_req;
      logic       clr_req;
      logic [5:0] exp;   // {s, r, ack_set, ack_clr, busy, q_shadow}
   } vec_t;

   vec_t tbl[$];

   task automatic step0(input string name, input logic [5:0] exp);
      @(negedge clk);
      check(name, 32'(o0), 32'(exp));
   endtask

   int run_s, run_r, gap, wait_set, wait_clr, set_acks_during_clr, clr_acks_during_set;
   logic had_pulse, dropped;

   initial begin
      // Init pulse, set, redundant set, clr, then both high with last_grant = clr.
      tbl.push_back('{1'b0, 1'b0, 6'b000010});
      tbl.push_back('{1'b0, 1'b0, 6'b010010});
      tbl.push_back('{1'b0, 1'b0, 6'b010010});
      tbl.push_back('{1'b0, 1'b0, 6'b000010});
      tbl.push_back('{1'b1, 1'b0, 6'b000000});
      tbl.push_back('{1'b1, 1'b0, 6'b100011});
      tbl.push_back('{1'b1, 1'b0, 6'b100011});
      tbl.push_back('{1'b1, 1'b0, 6'b001011});
      tbl.push_back('{1'b1, 1'b0, 6'b000001});
      tbl.push_back('{1'b1, 1'b0, 6'b001011});
      tbl.push_back('{1'b0, 1'b1, 6'b000001});
      tbl.push_back('{1'b0, 1'b1, 6'b010010});
      tbl.push_back('{1'b0, 1'b1, 6'b010010});
      tbl.push_back('{1'b0, 1'b1, 6'b000110});
      tbl.push_back('{1'b1, 1'b1, 6'b000000});
      tbl.push_back('{1'b1, 1'b1, 6'b100011});
      tbl.push_back('{1'b1, 1'b1, 6'b100011});
      tbl.push_back('{1'b1, 1'b1, 6'b001011});
      tbl.push_back('{1'b0, 1'b1, 6'b000001});
      tbl.push_back('{1'b0, 1'b1, 6'b010010});
      tbl.push_back('{1'b0, 1'b1, 6'b010010});
      tbl.push_back('{1'b0, 1'b1, 6'b000110});
      tbl.push_back('{1'b0, 1'b0, 6'b000000});

      for (int i = 0; i < 3; i++) step0("reset_state", 6'b000010);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         check($sformatf("table_row_%0d", i), 32'(o0), 32'(tbl[i].exp));
         rst  = 1'b0;
         set0 = tbl[i].set_req;
         clr0 = tbl[i].clr_req;
      end

      // Reset during the second cycle of an s pulse restarts the init sequence.
      set0 = 1'b1;
      step0("rst_mid_c1", 6'b100011);
      step0("rst_mid_c2", 6'b100011);
      rst = 1'b1; set0 = 1'b0;
      step0("rst_mid_c3", 6'b000010);
      rst = 1'b0;
      step0("rst_mid_init_c4", 6'b010010);
      step0("rst_mid_init_c5", 6'b010010);
      step0("rst_mid_init_c6", 6'b000010);
      step0("rst_mid_idle_c7", 6'b000000);
      set0 = 1'b1; clr0 = 1'b1;
      step0("rr_after_reset", 6'b100011);
      set0 = 1'b0; clr0 = 1'b0;
      repeat (4) @(negedge clk);
      check("dut0_idle_q1", 32'({busy0, q_shadow0, lq0}), 32'h3);

      // Random protocol-respecting stream on the 3/2 instance.
      run_s = 0; run_r = 0; gap = 0; had_pulse = 1'b0;
      wait_set = 0; wait_clr = 0; set_acks_during_clr = 0; clr_acks_during_set = 0;
      check("dut1_idle_start", 32'({busy1, q_shadow1}), 32'h0);
      for (int cyc = 0; cyc < 10000; cyc++) begin
         @(negedge clk);
         check("excl", 32'(s1 & r1), 32'h0);
         if (!s1 && run_s != 0) begin
            check("s_len", 32'(run_s), 32'd3); run_s = 0; gap = 0; had_pulse = 1'b1;
         end
         if (!r1 && run_r != 0) begin
            check("r_len", 32'(run_r), 32'd3); run_r = 0; gap = 0; had_pulse = 1'b1;
         end
         if (had_pulse && ((s1 && run_s == 0) || (r1 && run_r == 0)))
            check("gap_ge_2", 32'(gap >= 2), 32'h1);
         if (s1) run_s++;
         if (r1) run_r++;
         if (!s1 && !r1) gap++;

         if (set1) wait_set++;
         if (clr1) wait_clr++;
         check("wait_bound", 32'((wait_set > 30) || (wait_clr > 30)), 32'h0);

         dropped = 1'b0;
         if (ack_set1) begin
            check("ack_set_held", 32'(set1), 32'h1);
            check("latch1_set", 32'({lq1, q_shadow1}), 32'h3);
            if (clr1) set_acks_during_clr++;
            check("rr_clr_starved", 32'(set_acks_during_clr >= 2), 32'h0);
            clr_acks_during_set = 0;
            set1 = 1'b0; wait_set = 0; dropped = 1'b1;
         end
         if (ack_clr1) begin
            check("ack_clr_held", 32'(clr1), 32'h1);
            check("latch1_clr", 32'({lq1, q_shadow1}), 32'h0);
            if (set1) clr_acks_during_set++;
            check("rr_set_starved", 32'(clr_acks_during_set >= 2), 32'h0);
            set_acks_during_clr = 0;
            clr1 = 1'b0; wait_clr = 0; dropped = 1'b1;
         end
         if (!dropped) begin
            if (!set1 && $urandom_range(0, 2) == 0) begin
               set1 = 1'b1; wait_set = 0; clr_acks_during_set = 0;
            end
            if (!clr1 && $urandom_range(0, 2) == 0) begin
               clr1 = 1'b1; wait_clr = 0; set_acks_during_clr = 0;
            end
         end
      end
      set1 = 1'b0; clr1 = 1'b0;
      repeat (12) @(negedge clk);
      check("dut1_idle_end", 32'({busy1, s1, r1}), 32'h0);
      check("dut1_latch_end", 32'(lq1), 32'(q_shadow1));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
